// File: rtl/fire_pkg.sv
// Shared constants, types and the round/shift/saturate helper for the fire
// output stages.
package fire_pkg;

  localparam int CH    = 128;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int CH_W  = $clog2(CH);

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] act_t;
  typedef logic [CH_W-1:0]         ch_t;
  typedef logic signed [ACC_W:0]   sum_t;

  // Rounding arithmetic right shift at ACC_W+2 bits, then clamp into act_t.
  function automatic act_t sat_act(input sum_t sum, input int shift);
    logic signed [ACC_W+1:0] w_ext;
    logic signed [ACC_W+1:0] w_half;
    logic signed [ACC_W+1:0] w_r;
    logic signed [ACC_W+1:0] w_max;
    logic signed [ACC_W+1:0] w_min;
    w_ext  = {sum[ACC_W], sum};
    w_half = (ACC_W+2)'(1) << (shift - 1);
    w_r    = (w_ext + w_half) >>> shift;
    w_max  = (ACC_W+2)'((2 ** (OUT_W - 1)) - 1);
    w_min  = ~w_max;
    if (w_r > w_max) begin
      return w_max[OUT_W-1:0];
    end else if (w_r < w_min) begin
      return w_min[OUT_W-1:0];
    end
    return w_r[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/fire4_expand1_bias_act_if.sv
// Accumulator-in / activation-out stream bundle for the fire4 expand1 output stage.
// The stage itself uses the slave modport; the MAC array / consumer side uses master.
interface fire4_expand1_bias_act_if;
  import fire_pkg::*;

  logic acc_valid;
  logic acc_ready;
  acc_t acc_data;
  logic acc_last;
  logic out_valid;
  logic out_ready;
  act_t out_data;
  ch_t  out_ch;
  logic out_last;

  modport master (
    output acc_valid, acc_data, acc_last, out_ready,
    input  acc_ready, out_valid, out_data, out_ch, out_last
  );

  modport slave (
    input  acc_valid, acc_data, acc_last, out_ready,
    output acc_ready, out_valid, out_data, out_ch, out_last
  );

endinterface

// File: rtl/fire_requant.sv
// Stage 2: activation, rounding shift and saturation into a registered output slot.
// Define FIRE4_EXPAND1_RELU_EN to clamp negative sums to zero before rounding.
module fire_requant
  import fire_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_ready,
  input  sum_t i_sum,
  input  ch_t  i_ch,
  input  logic i_last,
  output logic o_valid,
  input  logic i_ready,
  output act_t o_data,
  output ch_t  o_ch,
  output logic o_last
);

  logic w_load;
  sum_t w_act;
  logic r_valid;
  act_t r_data;
  ch_t  r_ch;
  logic r_last;

  assign w_load  = !r_valid || i_ready;
  assign o_ready = w_load;

`ifdef FIRE4_EXPAND1_RELU_EN
  assign w_act = i_sum[ACC_W] ? '0 : i_sum;
`else
  assign w_act = i_sum;
`endif

  // Payload only moves with a real beat, so a stalled result never changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= sat_act(w_act, SHIFT);
        r_ch   <= i_ch;
        r_last <= i_last;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ch    = r_ch;
  assign o_last  = r_last;

endmodule

// File: rtl/fire4_expand1_bias_act.sv
// fire4 expand1x1 post-accumulation stage: bias add, activation, requantize, stream out.
// Optional ReLU clamp is enabled with FIRE4_EXPAND1_RELU_EN (see fire_requant).
module fire4_expand1_bias_act #(
  parameter int CH    = fire_pkg::CH,
  parameter int ACC_W = fire_pkg::ACC_W,
  parameter int OUT_W = fire_pkg::OUT_W,
  parameter int SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ACC_W-1:0]     bias_mem [0:CH-1],
  fire4_expand1_bias_act_if.slave bus,
  output logic [15:0]          pix_cnt,
  output logic                 sync_err
);
  import fire_pkg::*;

  localparam int CH_BITS = $clog2(CH);
  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(CH - 1);

  logic [CH_BITS-1:0]      r_ch;
  logic [15:0]             r_pix_cnt;
  logic                    r_sync_err;
  logic                    r_s1_valid;
  logic signed [ACC_W:0]   r_s1_sum;
  logic [CH_BITS-1:0]      r_s1_ch;
  logic                    r_s1_last;
  logic                    w_s2_load;
  logic                    w_acc_ready;
  logic                    w_accept;
  logic                    w_at_last;
  logic signed [ACC_W-1:0] w_bias;
  logic signed [OUT_W-1:0] w_out_data;

  assign w_bias      = bias_mem[r_ch];
  assign w_acc_ready = !rst && (!r_s1_valid || w_s2_load);
  assign w_accept    = bus.acc_valid && w_acc_ready;
  assign w_at_last   = (r_ch == LAST_CH);

  // An early acc_last resyncs the counter, but its own beat keeps the old channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch       <= '0;
      r_pix_cnt  <= '0;
      r_sync_err <= 1'b0;
    end else if (w_accept) begin
      if (w_at_last || bus.acc_last) begin
        r_ch      <= '0;
        r_pix_cnt <= r_pix_cnt + 16'd1;
        if (!w_at_last) begin
          r_sync_err <= 1'b1;
        end
      end else begin
        r_ch <= r_ch + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_ch    <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_acc_ready) begin
      r_s1_valid <= bus.acc_valid;
      if (bus.acc_valid) begin
        r_s1_sum  <= {bus.acc_data[ACC_W-1], bus.acc_data} + {w_bias[ACC_W-1], w_bias};
        r_s1_ch   <= r_ch;
        r_s1_last <= w_at_last;
      end
    end
  end

  fire_requant #(
    .SHIFT(SHIFT)
  ) u_requant (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_s1_valid),
    .o_ready (w_s2_load),
    .i_sum   (r_s1_sum),
    .i_ch    (r_s1_ch),
    .i_last  (r_s1_last),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_out_data),
    .o_ch    (bus.out_ch),
    .o_last  (bus.out_last)
  );

  assign bus.out_data  = w_out_data;
  assign bus.acc_ready = w_acc_ready;
  assign pix_cnt       = r_pix_cnt;
  assign sync_err      = r_sync_err;

endmodule
